// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU forwarding/scoreboard controller.
//   FPU_NSTG       : number of FPU pipeline stages tracked (one forward path each)
//   FPU_RW         : FP register index width
//   fpu_sb_entry_t : one in-flight scoreboard entry {v, wen, rd, rdy}
//                    rdy is the stage (1..4) at which the result becomes forwardable
package fpu_pkg;

    localparam int FPU_NSTG = 4;
    localparam int FPU_RW   = 5;

    typedef struct packed {
        logic              v;
        logic              wen;
        logic [FPU_RW-1:0] rd;
        logic [2:0]        rdy;
    } fpu_sb_entry_t;

endpackage

// File: rtl/fpu_fwd_ctrl_if.sv
// Decode-side bundle between the FP decode slot and the forwarding controller.
//   master : decode / pipeline control (drives dec_*, hold, flush)
//   slave  : fpu_fwd_ctrl (drives selects, stall, issue, writeback, stall counter)
interface fpu_fwd_ctrl_if
    import fpu_pkg::*;
#(
    parameter int RW = FPU_RW
) ();

    logic          dec_valid;
    logic [RW-1:0] dec_rs1;
    logic [RW-1:0] dec_rs2;
    logic          dec_use_rs1;
    logic          dec_use_rs2;
    logic          dec_wen;
    logic [RW-1:0] dec_rd;
    logic [1:0]    dec_lat;
    logic          hold;
    logic          flush;

    logic [3:0]    rs1_use;
    logic [3:0]    rs2_use;
    logic          stall;
    logic          issue;
    logic          wb_en;
    logic [RW-1:0] wb_rd;
    logic [15:0]   stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_wen, dec_rd, dec_lat, hold, flush,
        input  rs1_use, rs2_use, stall, issue, wb_en, wb_rd, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_wen, dec_rd, dec_lat, hold, flush,
        output rs1_use, rs2_use, stall, issue, wb_en, wb_rd, stall_cnt
    );

endinterface

// File: rtl/fpu_fwd_sel.sv
// Per-operand forward resolver (purely combinational).
//   stg     : scoreboard entries, index 0 = stage 1 (youngest)
//   rs      : source register index being read at decode
//   rd_en   : operand is actually read (already qualified with dec_valid)
//   sel     : one-hot bypass select, bit k-1 picks the stage-k result; 0 = register file
//   pending : youngest producer exists but its result is not ready yet
module fpu_fwd_sel
    import fpu_pkg::*;
(
    input  fpu_sb_entry_t        stg [FPU_NSTG],
    input  logic [FPU_RW-1:0]    rs,
    input  logic                 rd_en,
    output logic [FPU_NSTG-1:0]  sel,
    output logic                 pending
);

    logic found;

    // Scan from the youngest stage; the first hit shadows every older producer,
    // even if an older one is already ready.
    always_comb begin
        sel     = '0;
        pending = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < FPU_NSTG; k++) begin
            if (!found && rd_en && stg[k].v && stg[k].wen && (stg[k].rd == rs)) begin
                found = 1'b1;
                if (stg[k].rdy <= 3'(k + 1)) begin
                    sel[k] = 1'b1;
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_fwd_ctrl.sv
// Scoreboard and operand-bypass controller for the 4-stage FPU pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fpu_fwd_ctrl_if.slave
//                in : dec_valid, dec_rs1/2, dec_use_rs1/2, dec_wen, dec_rd, dec_lat, hold, flush
//                out: rs1_use, rs2_use (one-hot bypass selects), stall, issue,
//                     wb_en, wb_rd (register-file write from stage 4), stall_cnt (saturating)
module fpu_fwd_ctrl
    import fpu_pkg::*;
#(
    parameter int NSTG = FPU_NSTG,
    parameter int RW   = FPU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_fwd_ctrl_if.slave bus
);

    fpu_sb_entry_t stg [NSTG];
    fpu_sb_entry_t new_entry;
    logic [3:0]    rs1_sel;
    logic [3:0]    rs2_sel;
    logic          rs1_pend;
    logic          rs2_pend;
    logic          stall;
    logic          issue;
    logic [15:0]   stall_cnt;

    fpu_fwd_sel u_sel_rs1 (
        .stg     (stg),
        .rs      (bus.dec_rs1),
        .rd_en   (bus.dec_valid & bus.dec_use_rs1),
        .sel     (rs1_sel),
        .pending (rs1_pend)
    );

    fpu_fwd_sel u_sel_rs2 (
        .stg     (stg),
        .rs      (bus.dec_rs2),
        .rd_en   (bus.dec_valid & bus.dec_use_rs2),
        .sel     (rs2_sel),
        .pending (rs2_pend)
    );

    assign stall = bus.dec_valid & (rs1_pend | rs2_pend);
    assign issue = bus.dec_valid & ~stall & ~bus.hold & ~bus.flush;

    // dec_lat is "ready stage minus one", so the stored ready stage is 1..4.
    assign new_entry = '{v: 1'b1, wen: bus.dec_wen, rd: bus.dec_rd,
                         rdy: {1'b0, bus.dec_lat} + 3'd1};

    // Flush outranks hold: the kill must land even while the pipe is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                stg[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 0; k < NSTG; k++) begin
                stg[k] <= '0;
            end
        end else if (!bus.hold) begin
            for (int k = NSTG - 1; k > 0; k--) begin
                stg[k] <= stg[k-1];
            end
            stg[0] <= issue ? new_entry : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !bus.hold && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Stage 4 commits even in a flush cycle; it is older than the flush point.
    assign bus.wb_en     = stg[NSTG-1].v & stg[NSTG-1].wen & ~bus.hold;
    assign bus.wb_rd     = RW'(stg[NSTG-1].rd);
    assign bus.rs1_use   = rs1_sel;
    assign bus.rs2_use   = rs2_sel;
    assign bus.stall     = stall;
    assign bus.issue     = issue;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fpu_fwd_ctrl.sv
module tb_fpu_fwd_ctrl;

    logic clk;
    logic rst_n;

    fpu_fwd_ctrl_if bus ();

    fpu_fwd_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: list of in-flight instructions, oldest first.
    // age = number of pipeline advances since issue; stage = age + 1.
    typedef struct {
        int rd;
        bit wen;
        int ready_stage;
        int age;
    } minst_t;

    minst_t mq[$];
    int     m_stall_cnt;
    bit     e_issue;
    bit     e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void resolve(input int rs, input bit rd_en,
                                    output logic [3:0] sel, output bit pend);
        sel  = 4'b0000;
        pend = 1'b0;
        if (!rd_en) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].wen && mq[i].rd == rs) begin
                if (mq[i].ready_stage <= mq[i].age + 1)
                    sel = 4'(1 << mq[i].age);
                else
                    pend = 1'b1;
                return;
            end
        end
    endfunction

    task automatic setd(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input bit wen, input int rd, input int lat, input bit hd, input bit fl);
        bus.dec_valid   = v;
        bus.dec_rs1     = 5'(rs1);
        bus.dec_use_rs1 = u1;
        bus.dec_rs2     = 5'(rs2);
        bus.dec_use_rs2 = u2;
        bus.dec_wen     = wen;
        bus.dec_rd      = 5'(rd);
        bus.dec_lat     = 2'(lat);
        bus.hold        = hd;
        bus.flush       = fl;
    endtask

    task automatic idle();
        setd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called #1 after the falling edge, with inputs already applied.
    task automatic eval();
        logic [3:0] s1, s2;
        bit p1, p2;
        bit wb;
        int wrd;
        resolve(int'(bus.dec_rs1), bus.dec_valid && bus.dec_use_rs1, s1, p1);
        resolve(int'(bus.dec_rs2), bus.dec_valid && bus.dec_use_rs2, s2, p2);
        e_stall = bus.dec_valid && (p1 || p2);
        e_issue = bus.dec_valid && !e_stall && !bus.hold && !bus.flush;
        wb  = 1'b0;
        wrd = 0;
        foreach (mq[i]) if (mq[i].age == 3 && mq[i].wen) begin wb = !bus.hold; wrd = mq[i].rd; end
        chk("rs1_use", 32'(bus.rs1_use), 32'(s1));
        chk("rs2_use", 32'(bus.rs2_use), 32'(s2));
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("issue", 32'(bus.issue), 32'(e_issue));
        chk("wb_en", 32'(bus.wb_en), 32'(wb));
        if (wb) chk("wb_rd", 32'(bus.wb_rd), 32'(wrd));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall_cnt));
    endtask

    task automatic tick();
        minst_t n;
        @(posedge clk);
        if (e_stall && !bus.hold && m_stall_cnt < 65535) m_stall_cnt++;
        if (bus.flush) begin
            mq.delete();
        end else if (!bus.hold) begin
            foreach (mq[i]) mq[i].age++;
            while (mq.size() > 0 && mq[0].age >= 4) void'(mq.pop_front());
            if (e_issue) begin
                n.rd = int'(bus.dec_rd);
                n.wen = bus.dec_wen;
                n.ready_stage = int'(bus.dec_lat) + 1;
                n.age = 0;
                mq.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        #1;
        eval();
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            cyc();
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_stall_cnt = 0;
        chk("rst_rs1_use", 32'(bus.rs1_use), 0);
        chk("rst_rs2_use", 32'(bus.rs2_use), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_issue", 32'(bus.issue), 0);
        chk("rst_wb_en", 32'(bus.wb_en), 0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_sel [5];
        bit keep;
        int r1, r2, rd, lat;
        bit u1, u2, wen, v;

        rst_n = 1'b0;
        idle();
        m_stall_cnt = 0;
        @(negedge clk);
        do_reset();
        @(negedge clk);

        // Reset state with idle decode
        idle();
        cyc();

        // Lat-0 producer f3 forwarded from stages 1..4, then register file
        setd(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        #1; eval(); chk("t1_issue", 32'(bus.issue), 1); tick();
        exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0010; exp_sel[2] = 4'b0100;
        exp_sel[3] = 4'b1000; exp_sel[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            setd(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
            #1; eval();
            chk("t1_rs1_use", 32'(bus.rs1_use), 32'(exp_sel[i]));
            chk("t1_stall", 32'(bus.stall), 0);
            if (i == 3) begin
                chk("t1_wb_en", 32'(bus.wb_en), 1);
                chk("t1_wb_rd", 32'(bus.wb_rd), 3);
            end
            tick();
        end
        drain(4);

        // Lat-3 producer f5: three stall cycles then forward from stage 4
        setd(1, 0, 0, 0, 0, 1, 5, 3, 0, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            setd(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
            #1; eval();
            chk("t2_stall", 32'(bus.stall), 1);
            chk("t2_issue", 32'(bus.issue), 0);
            tick();
        end
        setd(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        #1; eval();
        chk("t2_rs2_use", 32'(bus.rs2_use), 32'(4'b1000));
        chk("t2_issue_after", 32'(bus.issue), 1);
        chk("t2_stall_cnt", 32'(bus.stall_cnt), 3);
        tick();
        drain(4);

        // WAW: youngest (not ready) producer shadows the older ready one
        setd(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); cyc();
        setd(1, 0, 0, 0, 0, 1, 2, 3, 0, 0); cyc();
        setd(1, 2, 1, 2, 1, 0, 0, 0, 0, 0);
        #1; eval();
        chk("t3_stall", 32'(bus.stall), 1);
        chk("t3_rs1_use", 32'(bus.rs1_use), 0);
        chk("t3_rs2_use", 32'(bus.rs2_use), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            setd(1, 2, 1, 2, 1, 0, 0, 0, 0, 0); cyc();
        end
        drain(4);

        // Flush with stages 1..4 occupied and a stalled decode
        setd(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); cyc();
        setd(1, 0, 0, 0, 0, 1, 1, 3, 0, 0); cyc();
        setd(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); cyc();
        setd(1, 0, 0, 0, 0, 1, 8, 0, 0, 0); cyc();
        setd(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        #1; eval();
        chk("t4_stall", 32'(bus.stall), 1);
        chk("t4_issue", 32'(bus.issue), 0);
        chk("t4_wb_en", 32'(bus.wb_en), 1);
        chk("t4_wb_rd", 32'(bus.wb_rd), 9);
        tick();
        setd(1, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        #1; eval();
        chk("t4_post_rs1", 32'(bus.rs1_use), 0);
        chk("t4_post_rs2", 32'(bus.rs2_use), 0);
        chk("t4_post_stall", 32'(bus.stall), 0);
        chk("t4_post_wb", 32'(bus.wb_en), 0);
        tick();
        drain(4);

        // Hold for two cycles with a lat-3 entry in stage 2
        setd(1, 0, 0, 0, 0, 1, 10, 3, 0, 0); cyc();
        idle(); cyc();
        for (int i = 0; i < 2; i++) begin
            setd(1, 10, 1, 0, 0, 0, 0, 0, 1, 0);
            #1; eval();
            chk("t5_hold_stall", 32'(bus.stall), 1);
            chk("t5_hold_issue", 32'(bus.issue), 0);
            chk("t5_hold_wb", 32'(bus.wb_en), 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            setd(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
            #1; eval(); chk("t5_rel_stall", 32'(bus.stall), 1); tick();
        end
        setd(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        #1; eval();
        chk("t5_rs1_use", 32'(bus.rs1_use), 32'(4'b1000));
        chk("t5_issue", 32'(bus.issue), 1);
        tick();
        drain(4);

        // Randomized traffic with a small register pool to provoke hazards
        keep = 1'b0;
        r1 = 0; r2 = 0; rd = 0; lat = 0; u1 = 0; u2 = 0; wen = 0; v = 0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                do_reset();
                @(negedge clk);
                keep = 1'b0;
            end
            if (!(keep && $urandom_range(0, 9) < 8)) begin
                v   = ($urandom_range(0, 9) < 8);
                r1  = $urandom_range(0, 3);
                r2  = $urandom_range(0, 3);
                u1  = $urandom_range(0, 1);
                u2  = $urandom_range(0, 1);
                wen = ($urandom_range(0, 9) < 7);
                rd  = $urandom_range(0, 3);
                lat = $urandom_range(0, 3);
            end
            setd(v, r1, u1, r2, u2, wen, rd, lat,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
            #1; eval();
            keep = bus.dec_valid && !e_issue;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
